fifo_mwpr: RTL

Multiple-write, parallel-read packing FIFO. Each cycle a producer pushes a variable number of entries (1..WR_NUM), packed contiguously. The consumer pops fixed groups of RD_NUM entries, presented show-ahead on `data_out`. It sits upstream of PE-block consumers that need dense fixed-width words assembled from sparse or compressed variable-length producer output. It is the write-side counterpart of the parallel-write / multi-read FIFO, with an optional zero-pad flush to close out a partial word.

---
 rtl/fifo_mwpr_if.sv | 30 +++
 rtl/fifo_mwpr.sv | 100 ++++++++++
 2 files changed

// File: rtl/fifo_mwpr_if.sv
// Handshake and data bundle for the packing FIFO.
// master drives requests, slave (the FIFO) drives status.
interface fifo_mwpr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int WR_NUM     = 4,
  parameter int RD_NUM     = 4
);
  localparam int PW = $clog2(WR_NUM) + 1;

  logic                         push;
  logic [PW-1:0]                push_num;
  logic [DATA_WIDTH*WR_NUM-1:0] data_in;
  logic                         flush;
  logic                         pop;
  logic [DATA_WIDTH*RD_NUM-1:0] data_out;
  logic [ADDR_WIDTH:0]          count;
  logic                         empty;
  logic                         full;

  modport master (
    output push, push_num, data_in, flush, pop,
    input  data_out, count, empty, full
  );

  modport slave (
    input  push, push_num, data_in, flush, pop,
    output data_out, count, empty, full
  );
endinterface

// File: rtl/fifo_mwpr.sv
// Multiple-write, parallel-read packing FIFO with zero-pad flush.
// Variable-size pushes are packed; pops take fixed RD_NUM groups.
module fifo_mwpr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int WR_NUM     = 4,
  parameter int RD_NUM     = 4
) (
  input logic        clk,
  input logic        Reset,
  fifo_mwpr_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] RD_W  = CW'(RD_NUM);
  localparam logic [CW-1:0] WR_W  = CW'(WR_NUM);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok, flush_ok;
  logic                  empty, full;
  logic [CW-1:0]         push_n, pad_n, adv_n;

  function automatic logic [ADDR_WIDTH-1:0] wrap(
    input logic [ADDR_WIDTH-1:0] p,
    input logic [CW-1:0]         n
  );
    logic [CW-1:0] s;
    s = CW'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return ADDR_WIDTH'(s);
  endfunction

  assign empty = count_q < RD_W;
  assign full  = (DEPTH - count_q) < WR_W;

  assign push_n   = CW'(bus.push_num);
  assign push_ok  = bus.push && !full && (push_n != '0);
  assign pop_ok   = bus.pop && !empty;
  // A push in the same cycle always wins over flush, even if rejected.
  assign flush_ok = bus.flush && !bus.push;
  // Distance to the next RD_NUM boundary; RD_NUM is a power of two.
  assign pad_n    = (CW'(0) - count_q) & (RD_W - CW'(1));

  always_comb begin
    adv_n = '0;
    if (push_ok)       adv_n = push_n;
    else if (flush_ok) adv_n = pad_n;
  end

  always_comb begin
    wr_ptr_d = wrap(wr_ptr_q, adv_n);
    rd_ptr_d = pop_ok ? wrap(rd_ptr_q, RD_W) : rd_ptr_q;
    count_d  = count_q + adv_n - (pop_ok ? RD_W : CW'(0));
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < WR_NUM; k++) begin
      if (push_ok && (CW'(k) < push_n))
        mem_d[wrap(wr_ptr_q, CW'(k))] =
          bus.data_in[DATA_WIDTH*k +: DATA_WIDTH];
    end
    for (int k = 0; k < RD_NUM; k++) begin
      if (flush_ok && (CW'(k) < pad_n))
        mem_d[wrap(wr_ptr_q, CW'(k))] = '0;
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int j = 0; j < RD_NUM; j++)
      bus.data_out[DATA_WIDTH*j +: DATA_WIDTH] =
        mem_q[wrap(rd_ptr_q, CW'(j))];
  end

  assign bus.count = count_q;
  assign bus.empty = empty;
  assign bus.full  = full;

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
